fir_tap_sequencer: RTL

Upstream control and storage stage for the 29-tap symmetric complex FIR datapath. It accepts one complex input sample per handshake and shifts it into a 29-entry delay line. It holds the 15 complex coefficients. It then sequences each sample through three fold phases, driving `mux_sel`, the partial-product accumulate qualifier and the final-accumulate enable, so the datapath produces one filter output per accepted sample.

---
 rtl/fir_tap_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//   Control and storage stage ahead of the 29-tap symmetric complex FIR
//   datapath. It accepts one complex sample per handshake into a 29-deep
//   delay line and holds the 15 complex coefficients. It then steps each
//   sample through three fold phases (mux_sel 0/1/2). A phase-tag pipeline
//   matches the multiplier latency and times the accumulate controls.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   PushIn, FI_in, FQ_in, StopIn    sample handshake (accept = PushIn & !StopIn)
//   coef_we, coef_addr, coef_I/Q    coefficient write port
//   coef_drop                       one-cycle pulse, cycle after a discarded write
//   samp[0..TAPS-1]                 delay line {I,Q}; samp[0] is newest
//   coef[0..NCOEF-1]                coefficient file {I,Q}
//   mux_sel                         fold phase 0/1/2
//   partialProductAccumulate_valid  accumulate p_prod into sub_prod
//   finalAccumulateRounding_en      sum the sub-products this cycle
//
// Optional feature (macro FIR_SEQ_FLUSH_EN): adds input flush and output
//   flush_busy. A flush pulse in IDLE pushes TAPS-1 zero samples through as
//   normal 3-phase groups. StopIn and flush_busy are held high throughout.
module fir_tap_sequencer #(
  parameter int TAPS     = 29,
  parameter int NCOEF    = 15,
  parameter int MULT_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PushIn,
  input  logic [23:0] FI_in,
  input  logic [23:0] FQ_in,
  output logic        StopIn,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [23:0] coef_I,
  input  logic [23:0] coef_Q,
  output logic        coef_drop,
  output logic [47:0] samp [TAPS],
  output logic [47:0] coef [NCOEF],
  output logic [1:0]  mux_sel,
  output logic        partialProductAccumulate_valid,
  output logic        finalAccumulateRounding_en
`ifdef FIR_SEQ_FLUSH_EN
  ,
  input  logic        flush,
  output logic        flush_busy
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, PH0 = 2'd1, PH1 = 2'd2, PH2 = 2'd3} state_t;

  state_t      state_r, state_nxt_s;
  logic        accept_s, shift_en_s, shift_zero_s, coef_ok_s, in_flight_s, stop_nxt_s;
  logic [1:0]  mux_sel_nxt_s;
  logic [2:0]  tag_s;
  logic [47:0] shift_data_s;
  logic [2:0]  tag_pipe_r [MULT_LAT+1];
  logic [47:0] samp_r [TAPS];
  logic [47:0] coef_r [NCOEF];
  logic        stop_r, coef_drop_r, fin_r;
  logic [1:0]  mux_sel_r;
`ifdef FIR_SEQ_FLUSH_EN
  logic        busy_r, busy_nxt_s;
  logic [4:0]  flush_cnt_r, flush_cnt_nxt_s;
`endif

  assign accept_s     = PushIn & ~stop_r;
  assign shift_data_s = shift_zero_s ? 48'd0 : {FI_in, FQ_in};
  // One-hot tag of the phase being issued this cycle; all zero in IDLE.
  assign tag_s        = {state_r == PH2, state_r == PH1, state_r == PH0};

  // A group is in flight while any phase tag is still travelling the pipeline.
  always_comb begin
    in_flight_s = 1'b0;
    for (int k = 0; k <= MULT_LAT; k++) begin
      in_flight_s = in_flight_s | (|tag_pipe_r[k]);
    end
  end

  // Coefficients may change only when no group can still be reading them.
  assign coef_ok_s = coef_we & (state_r == IDLE) & ~in_flight_s &
                     (coef_addr <= 4'(NCOEF - 1));

  // Next-state, delay-line shift control and flush bookkeeping.
  always_comb begin
    state_nxt_s  = state_r;
    shift_en_s   = 1'b0;
    shift_zero_s = 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
    busy_nxt_s      = busy_r;
    flush_cnt_nxt_s = flush_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = PH0;
          shift_en_s  = 1'b1;
        end
`ifdef FIR_SEQ_FLUSH_EN
        // A real sample arriving with flush wins; the flush is not started.
        else if (flush) begin
          state_nxt_s     = PH0;
          shift_en_s      = 1'b1;
          shift_zero_s    = 1'b1;
          busy_nxt_s      = 1'b1;
          flush_cnt_nxt_s = 5'(TAPS - 2);
        end
`endif
        else begin
          state_nxt_s = IDLE;
        end
      end
      PH0: state_nxt_s = PH1;
      PH1: state_nxt_s = PH2;
      PH2: begin
`ifdef FIR_SEQ_FLUSH_EN
        if (busy_r) begin
          if (flush_cnt_r != 5'd0) begin
            state_nxt_s     = PH0;
            shift_en_s      = 1'b1;
            shift_zero_s    = 1'b1;
            flush_cnt_nxt_s = flush_cnt_r - 5'd1;
          end else begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
          end
        end else if (accept_s) begin
`else
        if (accept_s) begin
`endif
          state_nxt_s = PH0;
          shift_en_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode of the next state so StopIn and mux_sel come straight from flops.
  always_comb begin
    stop_nxt_s = (state_nxt_s == PH0) || (state_nxt_s == PH1);
`ifdef FIR_SEQ_FLUSH_EN
    stop_nxt_s = stop_nxt_s | busy_nxt_s;
`endif
    case (state_nxt_s)
      PH1:     mux_sel_nxt_s = 2'd1;
      PH2:     mux_sel_nxt_s = 2'd2;
      default: mux_sel_nxt_s = 2'd0;
    endcase
  end

  // FSM state and registered handshake / phase / drop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      stop_r      <= 1'b0;
      mux_sel_r   <= 2'd0;
      coef_drop_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      stop_r      <= stop_nxt_s;
      mux_sel_r   <= mux_sel_nxt_s;
      coef_drop_r <= coef_we & ~coef_ok_s;
    end
  end

  // Phase-tag pipeline. The last stage lines up with p_prod. The final enable
  // fires the cycle after the PH2 product has been accumulated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= MULT_LAT; k++) begin
        tag_pipe_r[k] <= 3'b000;
      end
      fin_r <= 1'b0;
    end else begin
      tag_pipe_r[0] <= tag_s;
      for (int k = 1; k <= MULT_LAT; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
      fin_r <= tag_pipe_r[MULT_LAT][2];
    end
  end

  // Delay line. The shift lands at the edge entering PH0, so PH2 still sees
  // the pre-shift line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        samp_r[k] <= 48'd0;
      end
    end else if (shift_en_s) begin
      samp_r[0] <= shift_data_s;
      for (int k = 1; k < TAPS; k++) begin
        samp_r[k] <= samp_r[k-1];
      end
    end
  end

  // Coefficient register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCOEF; k++) begin
        coef_r[k] <= 48'd0;
      end
    end else if (coef_ok_s) begin
      coef_r[coef_addr] <= {coef_I, coef_Q};
    end
  end

`ifdef FIR_SEQ_FLUSH_EN
  // Flush busy flag and remaining zero-group count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r      <= 1'b0;
      flush_cnt_r <= 5'd0;
    end else begin
      busy_r      <= busy_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
    end
  end

  assign flush_busy = busy_r;
`endif

  assign StopIn                         = stop_r;
  assign mux_sel                        = mux_sel_r;
  assign coef_drop                      = coef_drop_r;
  assign partialProductAccumulate_valid = |tag_pipe_r[MULT_LAT][2:1];
  assign finalAccumulateRounding_en     = fin_r;
  assign samp                           = samp_r;
  assign coef                           = coef_r;

endmodule
